nonce_frame_decoder: RTL



---
 rtl/nonce_frame_decoder_if.sv | 31 +++
 rtl/nonce_frame_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nonce_frame_decoder_if.sv
// Byte-stream input and nonce/status outputs of the nonce frame decoder.
// The source side (UART receive path / bench) uses the master modport,
// the decoder itself uses the slave modport.
interface nonce_frame_decoder_if #(
    parameter int NONCE_BYTES = 8
);
    logic [7:0]               rx_data_i;
    logic                     rx_valid_i;
    logic [NONCE_BYTES*8-1:0] nonce_o;
    logic                     nonce_ready_o;
    logic                     nonce_ready_set_o;
    logic                     frame_error_o;

    modport master (
        output rx_data_i,
        output rx_valid_i,
        input  nonce_o,
        input  nonce_ready_o,
        input  nonce_ready_set_o,
        input  frame_error_o
    );

    modport slave (
        input  rx_data_i,
        input  rx_valid_i,
        output nonce_o,
        output nonce_ready_o,
        output nonce_ready_set_o,
        output frame_error_o
    );
endinterface

// File: rtl/nonce_frame_decoder.sv
// Assembles framed nonce load / clear commands from the UART byte stream.
// Frame: CMD_LOAD, NONCE_BYTES payload bytes (first byte ends up as MSB),
// then an XOR checksum byte. CMD_CLEAR outside a frame drops nonce-ready.
// Bad checksum or an inter-byte stall discards the frame and pulses
// frame_error_o. All outputs are registered; strobes are one cycle wide.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a command byte; other bytes ignored
// S_PAYLOAD | collecting payload bytes into the shift register
// S_CHECK   | waiting for the checksum byte
module nonce_frame_decoder #(
    parameter int         NONCE_BYTES    = 8,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] CMD_LOAD       = 8'h4E,
    parameter logic [7:0] CMD_CLEAR      = 8'h43
) (
    input logic               clk_i,
    input logic               rst_ni,
    nonce_frame_decoder_if.slave bus
);
    localparam int W  = NONCE_BYTES * 8;
    localparam int CW = $clog2(NONCE_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    // Last payload byte is accepted while the counter still reads NONCE_BYTES-1.
    localparam logic [CW-1:0] LP_LAST_BYTE = CW'(NONCE_BYTES - 1);
    // Expiry is the idle cycle whose increment would bring the counter to
    // TIMEOUT_CYCLES-1, so the counter itself never holds that value.
    localparam logic [TW-1:0] LP_TMO_LAST  = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_shift;
    logic [CW-1:0]   r_byte_cnt;
    logic [7:0]      r_csum;
    logic [TW-1:0]   r_tmo_cnt;

    logic [W-1:0]    r_nonce;
    logic            r_nonce_ready;
    logic            r_nonce_ready_set;
    logic            r_frame_error;

    logic            w_frame_open;
    logic            w_payload_byte;
    logic            w_load_good;
    logic            w_clear_cmd;
    logic            w_frame_err;
    logic            w_tmo_expire;
    logic            w_tmo_clr;

    assign w_tmo_expire = (r_state != S_IDLE) && !bus.rx_valid_i
                          && (r_tmo_cnt == LP_TMO_LAST);

    // Timer idles at zero outside a frame and restarts on every accepted byte.
    assign w_tmo_clr = bus.rx_valid_i || (r_state == S_IDLE)
                       || (w_state_nxt == S_IDLE);

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_frame_open   = 1'b0;
        w_payload_byte = 1'b0;
        w_load_good    = 1'b0;
        w_clear_cmd    = 1'b0;
        w_frame_err    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.rx_valid_i) begin
                    if (bus.rx_data_i == CMD_LOAD) begin
                        w_state_nxt  = S_PAYLOAD;
                        w_frame_open = 1'b1;
                    end else if (bus.rx_data_i == CMD_CLEAR) begin
                        w_clear_cmd = 1'b1;
                    end
                end
            end

            S_PAYLOAD: begin
                if (bus.rx_valid_i) begin
                    w_payload_byte = 1'b1;
                    if (r_byte_cnt == LP_LAST_BYTE) begin
                        w_state_nxt = S_CHECK;
                    end
                end else if (w_tmo_expire) begin
                    w_state_nxt = S_IDLE;
                    w_frame_err = 1'b1;
                end
            end

            S_CHECK: begin
                if (bus.rx_valid_i) begin
                    w_state_nxt = S_IDLE;
                    if (bus.rx_data_i == r_csum) begin
                        w_load_good = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end else if (w_tmo_expire) begin
                    w_state_nxt = S_IDLE;
                    w_frame_err = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame assembly: shift register, byte counter, checksum and stall timer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_csum     <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            if (w_frame_open) begin
                r_byte_cnt <= '0;
                r_csum     <= '0;
            end else if (w_payload_byte) begin
                r_shift    <= W'({r_shift, bus.rx_data_i});
                r_byte_cnt <= r_byte_cnt + CW'(1);
                r_csum     <= r_csum ^ bus.rx_data_i;
            end

            if (w_tmo_clr) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
        end
    end

    // Registered outputs: nonce word, ready level and the two strobes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_nonce           <= '0;
            r_nonce_ready     <= 1'b0;
            r_nonce_ready_set <= 1'b0;
            r_frame_error     <= 1'b0;
        end else begin
            r_nonce_ready_set <= w_load_good || w_clear_cmd;
            r_frame_error     <= w_frame_err;
            if (w_load_good) begin
                r_nonce       <= r_shift;
                r_nonce_ready <= 1'b1;
            end else if (w_clear_cmd) begin
                r_nonce_ready <= 1'b0;
            end
        end
    end

    assign bus.nonce_o           = r_nonce;
    assign bus.nonce_ready_o     = r_nonce_ready;
    assign bus.nonce_ready_set_o = r_nonce_ready_set;
    assign bus.frame_error_o     = r_frame_error;

endmodule
